product_pipe: RTL

Parallel lane-wise integer/fixed-point multiplier for the SpMV datapath, producing PARALLELISM element products per beat. It sits between the operand fetch stage and the reduction tree. It generalises the fixed-delay product unit with:
- selectable arithmetic mode and saturation,
- per-lane enables,
- per-lane overflow reporting,
- a true elastic pipeline that stalls correctly under downstream backpressure without losing or duplicating beats.

---
 rtl/product_pipe.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/product_pipe.sv
// Lane-parallel multiplier with an elastic DELAY-stage pipeline for the SpMV datapath.
// Supports unsigned, signed and fixed-point products with optional saturation and per-lane overflow.
module product_pipe #(
  parameter int DATA_WIDTH  = 16,
  parameter int PARALLELISM = 4,
  parameter int DELAY       = 4,
  parameter int MODE        = 1,
  parameter int FRAC_BITS   = 8,
  parameter int SATURATE    = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] a,
  input  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] b,
  input  logic [PARALLELISM-1:0]                 lane_en,
  output logic [PARALLELISM-1:0][DATA_WIDTH-1:0] out,
  output logic [PARALLELISM-1:0]                 ovf,
  output logic                                   valid,
  input  logic                                   ready,
  output logic [$clog2(DELAY+1)-1:0]             in_flight,
  output logic                                   sticky_ovf,
  input  logic                                   clr_sticky
);

  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DELAY + 1);

  localparam logic [W-1:0] MAX_S = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_S = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [PW-1:0] RND = PW'(1) << (FRAC_BITS - 1);

  // Returns {ovf, result}: range check of a signed wide value against W bits.
  function automatic logic [W:0] fit_signed(input logic signed [PW-1:0] v);
    logic         o;
    logic [W-1:0] res;
    o = !((&v[PW-1:W-1]) || !(|v[PW-1:W-1]));
    if (o && SATURATE != 0) res = v[PW-1] ? MIN_S : MAX_S;
    else                    res = v[W-1:0];
    return {o, res};
  endfunction

  function automatic logic [W:0] fit_unsigned(input logic [PW-1:0] v);
    logic         o;
    logic [W-1:0] res;
    o = |v[PW-1:W];
    if (o && SATURATE != 0) res = '1;
    else                    res = v[W-1:0];
    return {o, res};
  endfunction

  function automatic logic [W:0] lane_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic        [PW-1:0] up;
    logic signed [PW-1:0] sx, sy, p;
    if (MODE == 0) begin
      up = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      return fit_unsigned(up);
    end else begin
      sx = signed'({{W{x[W-1]}}, x});
      sy = signed'({{W{y[W-1]}}, y});
      p  = sx * sy;
      // Fixed-point: round half up, then drop the fractional bits.
      if (MODE == 2) return fit_signed((p + RND) >>> FRAC_BITS);
      else           return fit_signed(p);
    end
  endfunction

  logic [PARALLELISM-1:0][W-1:0] res_p0;
  logic [PARALLELISM-1:0]        ovf_p0;
  logic [PARALLELISM-1:0][W-1:0] res_p [1:DELAY];
  logic [PARALLELISM-1:0]        ovf_p [1:DELAY];
  logic [DELAY:1]                vld_p;
  logic [DELAY:1]                adv;
  logic [CW-1:0]                 occ;

  // Stage 0: combinational lane products on the incoming operands
  always_comb begin
    res_p0 = '0;
    ovf_p0 = '0;
    for (int i = 0; i < PARALLELISM; i++) begin
      if (lane_en[i]) {ovf_p0[i], res_p0[i]} = lane_mul(a[i], b[i]);
    end
  end

  // A stage may load when it is empty or its successor is moving.
  always_comb begin
    adv        = '0;
    adv[DELAY] = !vld_p[DELAY] || ready;
    for (int k = DELAY - 1; k >= 1; k--) adv[k] = !vld_p[k] || adv[k+1];
  end

  // Stages 1..DELAY: elastic register chain
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
      for (int k = 1; k <= DELAY; k++) begin
        res_p[k] <= '0;
        ovf_p[k] <= '0;
      end
    end else begin
      if (adv[1]) begin
        vld_p[1] <= in_valid;
        if (in_valid) begin
          res_p[1] <= res_p0;
          ovf_p[1] <= ovf_p0;
        end
      end
      for (int k = 2; k <= DELAY; k++) begin
        if (adv[k]) begin
          vld_p[k] <= vld_p[k-1];
          if (vld_p[k-1]) begin
            res_p[k] <= res_p[k-1];
            ovf_p[k] <= ovf_p[k-1];
          end
        end
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int k = 1; k <= DELAY; k++) occ = occ + CW'(vld_p[k]);
  end

  // Set has priority over clear so an overflow is never lost.
  always_ff @(posedge clk) begin
    if (rst)                            sticky_ovf <= 1'b0;
    else if (valid && ready && (|ovf))  sticky_ovf <= 1'b1;
    else if (clr_sticky)                sticky_ovf <= 1'b0;
  end

  assign in_ready  = adv[1];
  assign out       = res_p[DELAY];
  assign ovf       = ovf_p[DELAY];
  assign valid     = vld_p[DELAY];
  assign in_flight = occ;

endmodule
